alu_control_mc: RTL and testbench
=================================

// Module: alu_control_mc
// PURPOSE
//  Registered ALU control for the multicycle datapath. Decodes alu_op/funct to a
//  4-bit aluctrl with a valid/ready handshake; sequences iterative MULT (and
//  optional DIV) as DATA_W step cycles, then strobes the HI/LO write enable.
//  Sits between the main control unit and the ALU / HI-LO register file.
// PARAMETERS
//  DATA_W  32  operand width; MULT/DIV take exactly DATA_W step cycles (DATA_W >= 2)
//  CNT_W   $clog2(DATA_W)  step_cnt width (derived, do not override)
// PORTS
//  clk       in   1      rising-edge clock, single domain
//  reset     in   1      synchronous, active-high reset
//  in_valid  in   1      alu_op/funct valid this cycle
//  in_ready  out  1      block accepts a request (state==IDLE)
//  alu_op    in   2      00 add, 01 sub, 10 R-type (use funct), 11 reserved
//  funct     in   6      R-type function field
//  out_valid out  1      aluctrl valid this cycle
//  aluctrl   out  4      ALU operation code
//  step_cnt  out  CNT_W  current MULT/DIV step index
//  busy      out  1      state != IDLE
//  done      out  1      one-cycle pulse: multicycle op finished
//  hilo_we   out  1      one-cycle HI/LO write enable (same cycle as done)
//  illegal   out  1      one-cycle pulse with out_valid: undecodable request
// BEHAVIOUR
//  Accept = in_valid & in_ready at a rising edge; in_valid ignored otherwise and
//   while reset is high. in_ready is combinational (state==IDLE); all other
//   outputs registered.
//  Decode: alu_op 00->0010, 01->0110, 11->1111+illegal. alu_op 10: 100000->0010
//   add, 100010->0110 sub, 100100->0000 and, 100101->0001 or, 101010->0111 slt,
//   100111->1100 nor, 011000->MULT, 011010->DIV (macro), else 1111+illegal.
//  Single-cycle op: latency 1 -- out_valid=1 with aluctrl the cycle after accept,
//   for one cycle; state stays IDLE, so back-to-back accepts give out_valid
//   every cycle. No output backpressure.
//  FSM: IDLE -> MUL | DIV on MULT/DIV accept; step_cnt cleared to 0 on entry.
//   MUL: out_valid=1, aluctrl=1000 each cycle; step_cnt increments.
//   DIV: same with aluctrl=1001.
//   On step_cnt==DATA_W-1 -> DONE; no wrap past DATA_W-1.
//   DONE: out_valid=0, done=1, hilo_we=1 for one cycle -> IDLE. step_cnt holds
//   DATA_W-1 in DONE, cleared in IDLE.
//  First step cycle is the cycle after accept. Accept to done = DATA_W+1 cycles.
//  Requests during MUL/DIV/DONE are not accepted: in_ready=0; requester holds.
//  Reset values: state IDLE, out_valid 0, aluctrl 0000, step_cnt 0, busy 0,
//   done 0, hilo_we 0, illegal 0.
//  Reset mid-op: aborts at next edge; no done/hilo_we pulse; in_ready=1 the
//   first cycle with reset low.
//  Reset asserted with in_valid high: request dropped.
// CONFIGURATION
//  ALU_CTRL_DIV_EN defined: funct 011010 enters DIV (aluctrl 1001 steps).
//  Not defined: 011010 decodes as illegal (1111, single cycle); DIV state and
//   1001 encoding are not generated.
// TESTING
//  1 reset; alu_op=00 accept -> next cycle out_valid=1, aluctrl=0010, illegal=0
//  2 alu_op=10, funct 101010 then 100111 back-to-back -> aluctrl 0111 then 1100
//    on consecutive cycles, out_valid held 1
//  3 DATA_W=8, funct 011000 -> in_ready=0; 8 cycles aluctrl=1000, step_cnt 0..7;
//    then done=hilo_we=1 one cycle; in_ready=1 next; in_valid during busy ignored
//  4 alu_op=10, funct 111111 -> aluctrl=1111, illegal=1 for one cycle, busy=0
//  5 reset high at step_cnt=3 of MULT -> next cycle busy=0, out_valid=0,
//    step_cnt=0; no done/hilo_we
//  6 funct 011010: with ALU_CTRL_DIV_EN -> 8 steps aluctrl=1001 + done; without
//    it -> aluctrl=1111, illegal=1

Source files
------------

// File: rtl/alu_control_mc.sv
// rtl/alu_control_mc.sv - registered ALU control with iterative MULT/DIV sequencing (optional DIV: ALU_CTRL_DIV_EN)
module alu_control_mc #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    output logic             out_valid,
    output logic [3:0]       aluctrl,
    output logic [CNT_W-1:0] step_cnt,
    output logic             busy,
    output logic             done,
    output logic             hilo_we,
    output logic             illegal
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
`ifdef ALU_CTRL_DIV_EN
    localparam logic [1:0] S_DIV  = 2'd2;
`endif
    localparam logic [1:0] S_DONE = 2'd3;

    // Final step index; the step counter never wraps past this value.
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             accept;
    logic [3:0]       dec_code;
    logic             dec_ill;
    logic             dec_mul;
`ifdef ALU_CTRL_DIV_EN
    logic             dec_div;
`endif
    logic             out_valid_nxt;
    logic [3:0]       aluctrl_nxt;
    logic [CNT_W-1:0] step_cnt_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             hilo_we_nxt;
    logic             illegal_nxt;

    assign in_ready = (state == S_IDLE);
    assign accept   = in_valid & in_ready;

    // Decode alu_op/funct into an ALU code and multicycle/illegal flags.
    always_comb begin
        dec_code = 4'b1111;
        dec_ill  = 1'b0;
        dec_mul  = 1'b0;
`ifdef ALU_CTRL_DIV_EN
        dec_div  = 1'b0;
`endif
        case (alu_op)
            2'b00: dec_code = 4'b0010;
            2'b01: dec_code = 4'b0110;
            2'b10: begin
                case (funct)
                    6'b100000: dec_code = 4'b0010;
                    6'b100010: dec_code = 4'b0110;
                    6'b100100: dec_code = 4'b0000;
                    6'b100101: dec_code = 4'b0001;
                    6'b101010: dec_code = 4'b0111;
                    6'b100111: dec_code = 4'b1100;
                    6'b011000: begin
                        dec_code = 4'b1000;
                        dec_mul  = 1'b1;
                    end
`ifdef ALU_CTRL_DIV_EN
                    6'b011010: begin
                        dec_code = 4'b1001;
                        dec_div  = 1'b1;
                    end
`endif
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Next-state logic: enter a step state on MULT/DIV accept, leave after the last step.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && dec_mul) state_nxt = S_MUL;
`ifdef ALU_CTRL_DIV_EN
                if (accept && dec_div) state_nxt = S_DIV;
`endif
            end
            S_MUL
`ifdef ALU_CTRL_DIV_EN
            , S_DIV
`endif
            : begin
                if (step_cnt == LAST_STEP) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        out_valid_nxt = 1'b0;
        aluctrl_nxt   = aluctrl;
        step_cnt_nxt  = '0;
        done_nxt      = 1'b0;
        hilo_we_nxt   = 1'b0;
        illegal_nxt   = 1'b0;
        busy_nxt      = (state_nxt != S_IDLE);
        case (state)
            S_IDLE: begin
                if (accept) begin
                    out_valid_nxt = 1'b1;
                    aluctrl_nxt   = dec_code;
                    illegal_nxt   = dec_ill;
                end
            end
            S_MUL
`ifdef ALU_CTRL_DIV_EN
            , S_DIV
`endif
            : begin
                if (step_cnt == LAST_STEP) begin
                    step_cnt_nxt = step_cnt;
                    done_nxt     = 1'b1;
                    hilo_we_nxt  = 1'b1;
                end else begin
                    out_valid_nxt = 1'b1;
                    step_cnt_nxt  = step_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            aluctrl   <= 4'b0000;
            step_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hilo_we   <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= out_valid_nxt;
            aluctrl   <= aluctrl_nxt;
            step_cnt  <= step_cnt_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            hilo_we   <= hilo_we_nxt;
            illegal   <= illegal_nxt;
        end
    end

endmodule

// File: tb/tb_alu_control_mc.sv
// tb/tb_alu_control_mc.sv - directed table-driven bench for alu_control_mc
module tb_alu_control_mc;

    localparam int DATA_W = 8;
    localparam int CNT_W  = $clog2(DATA_W);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       alu_op = 2'b00;
    logic [5:0]       funct = 6'b000000;
    logic             out_valid;
    logic [3:0]       aluctrl;
    logic [CNT_W-1:0] step_cnt;
    logic             busy;
    logic             done;
    logic             hilo_we;
    logic             illegal;

    int checks = 0;
    int errors = 0;

    alu_control_mc #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct     (funct),
        .out_valid (out_valid),
        .aluctrl   (aluctrl),
        .step_cnt  (step_cnt),
        .busy      (busy),
        .done      (done),
        .hilo_we   (hilo_we),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] exp_code;
        logic       exp_ill;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one MULT/DIV request, hold in_valid during busy, check every step and the done pulse.
    task automatic run_multi(input logic [5:0] fn, input logic [3:0] exp_code);
        alu_op   = 2'b10;
        funct    = fn;
        in_valid = 1'b1;
        chk("mc_ready_before", {31'd0, in_ready}, 1);
        step();
        funct = 6'b100000;
        for (int i = 0; i < DATA_W; i++) begin
            chk("mc_in_ready", {31'd0, in_ready}, 0);
            chk("mc_busy", {31'd0, busy}, 1);
            chk("mc_out_valid", {31'd0, out_valid}, 1);
            chk("mc_aluctrl", {28'd0, aluctrl}, {28'd0, exp_code});
            chk("mc_step_cnt", {{(32-CNT_W){1'b0}}, step_cnt}, i);
            chk("mc_no_done", {31'd0, done}, 0);
            step();
        end
        in_valid = 1'b0;
        chk("mc_done", {31'd0, done}, 1);
        chk("mc_hilo_we", {31'd0, hilo_we}, 1);
        chk("mc_done_out_valid", {31'd0, out_valid}, 0);
        chk("mc_done_step_cnt", {{(32-CNT_W){1'b0}}, step_cnt}, DATA_W - 1);
        chk("mc_done_in_ready", {31'd0, in_ready}, 0);
        step();
        chk("mc_after_done", {31'd0, done}, 0);
        chk("mc_after_hilo_we", {31'd0, hilo_we}, 0);
        chk("mc_after_in_ready", {31'd0, in_ready}, 1);
        chk("mc_after_busy", {31'd0, busy}, 0);
        chk("mc_after_out_valid", {31'd0, out_valid}, 0);
        chk("mc_after_step_cnt", {{(32-CNT_W){1'b0}}, step_cnt}, 0);
    endtask

    initial begin
        vecs.push_back('{2'b00, 6'b000000, 4'b0010, 1'b0});
        vecs.push_back('{2'b01, 6'b111111, 4'b0110, 1'b0});
        vecs.push_back('{2'b10, 6'b101010, 4'b0111, 1'b0});
        vecs.push_back('{2'b10, 6'b100111, 4'b1100, 1'b0});
        vecs.push_back('{2'b10, 6'b100000, 4'b0010, 1'b0});
        vecs.push_back('{2'b10, 6'b100010, 4'b0110, 1'b0});
        vecs.push_back('{2'b10, 6'b100100, 4'b0000, 1'b0});
        vecs.push_back('{2'b10, 6'b100101, 4'b0001, 1'b0});
        vecs.push_back('{2'b10, 6'b111111, 4'b1111, 1'b1});
        vecs.push_back('{2'b11, 6'b100000, 4'b1111, 1'b1});
        vecs.push_back('{2'b10, 6'b000000, 4'b1111, 1'b1});
        vecs.push_back('{2'b00, 6'b011000, 4'b0010, 1'b0});

        // Reset with a pending request: the request must be dropped.
        reset    = 1'b1;
        in_valid = 1'b1;
        alu_op   = 2'b00;
        step();
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_aluctrl", {28'd0, aluctrl}, 0);
        chk("rst_step_cnt", {{(32-CNT_W){1'b0}}, step_cnt}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_hilo_we", {31'd0, hilo_we}, 0);
        chk("rst_illegal", {31'd0, illegal}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        step();
        chk("rst_dropped", {31'd0, out_valid}, 0);

        // Back-to-back single-cycle decodes.
        for (int i = 0; i < vecs.size(); i++) begin
            alu_op   = vecs[i].op;
            funct    = vecs[i].fn;
            in_valid = 1'b1;
            step();
            chk("vec_out_valid", {31'd0, out_valid}, 1);
            chk("vec_aluctrl", {28'd0, aluctrl}, {28'd0, vecs[i].exp_code});
            chk("vec_illegal", {31'd0, illegal}, {31'd0, vecs[i].exp_ill});
            chk("vec_busy", {31'd0, busy}, 0);
            chk("vec_in_ready", {31'd0, in_ready}, 1);
        end
        in_valid = 1'b0;
        step();
        chk("idle_out_valid", {31'd0, out_valid}, 0);
        chk("idle_illegal", {31'd0, illegal}, 0);

        // Full MULT sequence.
        run_multi(6'b011000, 4'b1000);

        // Reset at step 3 of MULT aborts without a done pulse.
        alu_op   = 2'b10;
        funct    = 6'b011000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        chk("abort_step3", {{(32-CNT_W){1'b0}}, step_cnt}, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_out_valid", {31'd0, out_valid}, 0);
        chk("abort_step_cnt", {{(32-CNT_W){1'b0}}, step_cnt}, 0);
        chk("abort_in_ready", {31'd0, in_ready}, 1);
        for (int i = 0; i < DATA_W + 2; i++) begin
            chk("abort_no_done", {31'd0, done}, 0);
            chk("abort_no_hilo_we", {31'd0, hilo_we}, 0);
            step();
        end

        // DIV funct: multicycle when enabled, illegal otherwise.
`ifdef ALU_CTRL_DIV_EN
        run_multi(6'b011010, 4'b1001);
`else
        alu_op   = 2'b10;
        funct    = 6'b011010;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("div_off_aluctrl", {28'd0, aluctrl}, 32'hF);
        chk("div_off_illegal", {31'd0, illegal}, 1);
        chk("div_off_out_valid", {31'd0, out_valid}, 1);
        chk("div_off_busy", {31'd0, busy}, 0);
        step();
        chk("div_off_ill_pulse", {31'd0, illegal}, 0);
        chk("div_off_ov_pulse", {31'd0, out_valid}, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
